// File: rtl/burst_to_apb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : burst_to_apb_master_if
//  Description : Bundles the three buses of the burst-to-APB master bridge:
//                the command/write burst input (bst_*), the APB master
//                (paddr/psel/penable/pwrite/pwdata/prdata/plsverr), the read
//                return burst (rd_*) and the err/idle status pair.
//                Modport "master" is the bridge view; modport "slave" is the
//                view of whatever sits around the bridge.
//  Revision    : 1.0  initial release
// ============================================================================
interface burst_to_apb_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    // Input burst
    logic              bst_valid;
    logic              bst_ready;
    logic [DATA_W-1:0] bst_data;
    logic              bst_last;
    // APB
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              plsverr;
    // Read return burst
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    // Status
    logic              err;
    logic              idle;

    modport master (
        input  bst_valid, bst_data, bst_last,
        output bst_ready,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, plsverr,
        output rd_valid, rd_data, rd_last,
        input  rd_ready,
        output err, idle
    );

    modport slave (
        output bst_valid, bst_data, bst_last,
        input  bst_ready,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, plsverr,
        input  rd_valid, rd_data, rd_last,
        output rd_ready,
        input  err, idle
    );
endinterface
`default_nettype wire

// File: rtl/burst_to_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : burst_to_apb_master
//  Description : Accepts a valid/ready byte burst (CMD, ADDR, then write data
//                or a read LEN) and replays it as zero-wait-state two-phase
//                APB transfers on a 9-bit address space. Read data comes back
//                as a valid/ready burst with rd_last on the final beat.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - burst_to_apb_master_if.master: bst_* input burst,
//                         APB master signals, rd_* read return, err (sticky
//                         per command), idle (no command in progress)
//  Revision    : 1.0  initial release
// ============================================================================
module burst_to_apb_master #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    burst_to_apb_master_if.master        bus
);

    localparam int CNT_W = DATA_W + 1;   // holds 1..256 remaining reads

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_LEN    = 3'd2,
        S_WDATA  = 3'd3,
        S_SETUP  = 3'd4,
        S_ACCESS = 3'd5,
        S_RHOLD  = 3'd6,
        S_DRAIN  = 3'd7
    } state_t;

    state_t              r_state,    w_state_n;
    logic [ADDR_W-1:0]   r_paddr,    w_paddr_n;
    logic                r_pwrite,   w_pwrite_n;
    logic [DATA_W-1:0]   r_pwdata,   w_pwdata_n;
    logic                r_wlast,    w_wlast_n;
    logic [CNT_W-1:0]    r_cnt,      w_cnt_n;
    logic                r_rd_valid, w_rd_valid_n;
    logic [DATA_W-1:0]   r_rd_data,  w_rd_data_n;
    logic                r_rd_last,  w_rd_last_n;
    logic                r_err,      w_err_n;
    logic                r_psel;
    logic                r_penable;
    logic                r_bst_ready;
    logic                r_idle;
    logic                w_bst_hs;

    assign w_bst_hs = bus.bst_valid && r_bst_ready;

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n    = r_state;
        w_paddr_n    = r_paddr;
        w_pwrite_n   = r_pwrite;
        w_pwdata_n   = r_pwdata;
        w_wlast_n    = r_wlast;
        w_cnt_n      = r_cnt;
        w_rd_valid_n = r_rd_valid;
        w_rd_data_n  = r_rd_data;
        w_rd_last_n  = r_rd_last;
        w_err_n      = r_err;

        case (r_state)
            S_IDLE: begin
                if (w_bst_hs) begin
                    w_pwrite_n           = bus.bst_data[DATA_W-1];
                    w_paddr_n[ADDR_W-1]  = bus.bst_data[0];
                    // A one-beat burst is malformed: flag it and stay put.
                    if (bus.bst_last) begin
                        w_err_n = 1'b1;
                    end else begin
                        w_err_n   = 1'b0;
                        w_state_n = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (w_bst_hs) begin
                    w_paddr_n[DATA_W-1:0] = bus.bst_data;
                    if (bus.bst_last) begin
                        w_err_n   = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = r_pwrite ? S_WDATA : S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (w_bst_hs) begin
                    w_cnt_n   = (bus.bst_data == '0) ? {1'b1, {DATA_W{1'b0}}}
                                                     : {1'b0, bus.bst_data};
                    // Extra beats after LEN are flushed before reads start.
                    w_state_n = bus.bst_last ? S_SETUP : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_bst_hs && bus.bst_last) begin
                    w_state_n = S_SETUP;
                end
            end
            S_WDATA: begin
                if (w_bst_hs) begin
                    w_pwdata_n = bus.bst_data;
                    w_wlast_n  = bus.bst_last;
                    w_state_n  = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_n = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.plsverr) begin
                    w_err_n = 1'b1;
                end
                // Address moves on only after the access phase, so paddr
                // stays put across SETUP and ACCESS.
                w_paddr_n = r_paddr + ADDR_W'(1);
                if (r_pwrite) begin
                    w_state_n = r_wlast ? S_IDLE : S_WDATA;
                end else begin
                    w_rd_data_n  = bus.prdata;
                    w_rd_valid_n = 1'b1;
                    w_rd_last_n  = (r_cnt == CNT_W'(1));
                    w_cnt_n      = r_cnt - CNT_W'(1);
                    w_state_n    = S_RHOLD;
                end
            end
            S_RHOLD: begin
                if (bus.rd_ready) begin
                    w_rd_valid_n = 1'b0;
                    w_rd_last_n  = 1'b0;
                    w_state_n    = (r_cnt != '0) ? S_SETUP : S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Bus strobes are decoded from the next
    // state so every output comes straight from a flop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_wlast     <= 1'b0;
            r_cnt       <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_last   <= 1'b0;
            r_err       <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_bst_ready <= 1'b1;
            r_idle      <= 1'b1;
        end else begin
            r_state     <= w_state_n;
            r_paddr     <= w_paddr_n;
            r_pwrite    <= w_pwrite_n;
            r_pwdata    <= w_pwdata_n;
            r_wlast     <= w_wlast_n;
            r_cnt       <= w_cnt_n;
            r_rd_valid  <= w_rd_valid_n;
            r_rd_data   <= w_rd_data_n;
            r_rd_last   <= w_rd_last_n;
            r_err       <= w_err_n;
            r_psel      <= (w_state_n == S_SETUP) || (w_state_n == S_ACCESS);
            r_penable   <= (w_state_n == S_ACCESS);
            r_bst_ready <= (w_state_n != S_SETUP) && (w_state_n != S_ACCESS) &&
                           (w_state_n != S_RHOLD);
            r_idle      <= (w_state_n == S_IDLE);
        end
    end

    assign bus.bst_ready = r_bst_ready;
    assign bus.paddr     = r_paddr;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.pwdata    = r_pwdata;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_last   = r_rd_last;
    assign bus.err       = r_err;
    assign bus.idle      = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_burst_to_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_to_apb_master
//  Description : Self-checking bench for burst_to_apb_master. An APB slave
//                memory answers transfers; a separate reference memory and
//                per-burst expectations decide what the bridge must do.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_burst_to_apb_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    burst_to_apb_master_if #(.ADDR_W(9), .DATA_W(8)) bus_if ();

    burst_to_apb_master #(.ADDR_W(9), .DATA_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    typedef struct packed { logic wr; logic [8:0] addr; logic [7:0] data; } apb_t;
    typedef struct packed { logic [7:0] data; logic last; } rd_t;
    typedef struct packed {
        logic       wr;
        logic [8:0] addr;
        logic [8:0] n;
        logic [31:0] d;        // byte i at [8i+:8]: write data or slave contents
        logic [7:0] mask;      // plsverr on access i when bit i set
        logic [8:0] exp_last;  // address of the final transfer
        logic       exp_err;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] slave_mem [512];
    logic [7:0] ref_mem   [512];
    logic [7:0] burst_data [256];
    apb_t       apb_log [$];
    rd_t        rd_log  [$];
    logic [255:0] err_mask;
    int         xfer_idx;
    int         violations;
    int         rd_hold = 0;
    bit         rd_rand = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- APB slave and read-return monitor ----------------
    logic       prev_setup = 1'b0;
    logic [8:0] s_addr;
    logic       s_wr;
    logic [7:0] s_wdata;
    logic       prev_held = 1'b0;
    rd_t        held;

    initial begin
        bus_if.prdata  = '0;
        bus_if.plsverr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_setup = 1'b0;
                prev_held  = 1'b0;
            end else begin
                if (bus_if.penable && !bus_if.psel) violations++;
                if (bus_if.psel && !bus_if.penable) begin
                    if (prev_setup) violations++;
                    prev_setup     = 1'b1;
                    s_addr         = bus_if.paddr;
                    s_wr           = bus_if.pwrite;
                    s_wdata        = bus_if.pwdata;
                    bus_if.prdata  = slave_mem[bus_if.paddr];
                    bus_if.plsverr = (xfer_idx < 256) ? err_mask[xfer_idx[7:0]] : 1'b0;
                end else if (bus_if.psel && bus_if.penable) begin
                    apb_t e;
                    if (!prev_setup || s_addr != bus_if.paddr || s_wr != bus_if.pwrite ||
                        (s_wr && s_wdata != bus_if.pwdata)) violations++;
                    prev_setup = 1'b0;
                    e.wr   = bus_if.pwrite;
                    e.addr = bus_if.paddr;
                    e.data = bus_if.pwrite ? bus_if.pwdata : bus_if.prdata;
                    apb_log.push_back(e);
                    if (bus_if.pwrite) slave_mem[bus_if.paddr] = bus_if.pwdata;
                    xfer_idx++;
                end else begin
                    if (prev_setup) violations++;
                    prev_setup     = 1'b0;
                    bus_if.plsverr = 1'b0;
                end
                if (bus_if.rd_valid) begin
                    rd_t r;
                    r.data = bus_if.rd_data;
                    r.last = bus_if.rd_last;
                    if (bus_if.psel) violations++;
                    if (prev_held && r != held) violations++;
                    if (bus_if.rd_ready) begin
                        rd_log.push_back(r);
                        prev_held = 1'b0;
                    end else begin
                        prev_held = 1'b1;
                        held      = r;
                    end
                end else if (prev_held) begin
                    violations++;
                    prev_held = 1'b0;
                end
            end
        end
    end

    // ---------------- read-return consumer ----------------
    initial begin
        int hold_cnt = 0;
        bus_if.rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.rd_valid) begin
                if (hold_cnt >= rd_hold) bus_if.rd_ready = 1'b1;
                else begin
                    bus_if.rd_ready = 1'b0;
                    hold_cnt++;
                end
            end else begin
                bus_if.rd_ready = 1'b0;
                hold_cnt = 0;
                if (rd_rand) rd_hold = $urandom_range(0, 3);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] d, input bit l);
        int n = 0;
        bus_if.bst_valid = 1'b1;
        bus_if.bst_data  = d;
        bus_if.bst_last  = l;
        forever begin
            @(negedge clk);
            if (bus_if.bst_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 2000) begin
                check("send_timeout", {31'd0, bus_if.bst_ready}, 32'd1);
                @(posedge clk);
                #1;
                break;
            end
        end
        bus_if.bst_valid = 1'b0;
        bus_if.bst_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus_if.idle && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, {31'd0, bus_if.idle}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_logs(input bit wr, input logic [8:0] a, input int n, input string tag);
        logic [8:0] ea;
        check({tag, "_apb_count"}, apb_log.size(), n);
        if (!wr) check({tag, "_rd_count"}, rd_log.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = a + 9'(i);
            if (i < apb_log.size()) begin
                check({tag, "_addr"}, {23'd0, apb_log[i].addr}, {23'd0, ea});
                check({tag, "_dir"}, {31'd0, apb_log[i].wr}, {31'd0, wr});
                if (wr) check({tag, "_wdata"}, {24'd0, apb_log[i].data}, {24'd0, burst_data[i]});
            end
            if (wr) ref_mem[ea] = burst_data[i];
            else if (i < rd_log.size()) begin
                check({tag, "_rdata"}, {24'd0, rd_log[i].data}, {24'd0, ref_mem[ea]});
                check({tag, "_rlast"}, {31'd0, rd_log[i].last}, {31'd0, (i == n - 1)});
            end
        end
        check({tag, "_protocol"}, violations, 0);
    endtask

    task automatic run_burst(input bit wr, input logic [8:0] a, input int n,
                             input logic [255:0] mask, input bit exp_err, input string tag);
        apb_log.delete();
        rd_log.delete();
        xfer_idx   = 0;
        err_mask   = mask;
        violations = 0;
        send({wr, 6'd0, a[8]}, 1'b0);
        check({tag, "_err_clear"}, {31'd0, bus_if.err}, 32'd0);
        send(a[7:0], 1'b0);
        if (wr) for (int i = 0; i < n; i++) send(burst_data[i], i == n - 1);
        else    send(n[7:0], 1'b1);
        wait_idle(tag);
        compare_logs(wr, a, n, tag);
        check({tag, "_err"}, {31'd0, bus_if.err}, {31'd0, exp_err});
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 9'h010, 9'd3, 32'h00C3B2A1, 8'h00, 9'h012, 1'b0};
        vecs[1] = '{1'b0, 9'h1FE, 9'd3, 32'h00332211, 8'h00, 9'h000, 1'b0};
        vecs[2] = '{1'b1, 9'h0F0, 9'd2, 32'h0000A55A, 8'h01, 9'h0F1, 1'b1};
        vecs[3] = '{1'b0, 9'h100, 9'd1, 32'h0000007E, 8'h00, 9'h100, 1'b0};
        vecs[4] = '{1'b1, 9'h1FF, 9'd2, 32'h00000201, 8'h00, 9'h000, 1'b0};
        vecs[5] = '{1'b0, 9'h055, 9'd2, 32'h0000DEC0, 8'h02, 9'h056, 1'b1};

        for (int i = 0; i < 512; i++) begin
            slave_mem[i] = 8'($urandom);
            ref_mem[i]   = slave_mem[i];
        end
        err_mask = '0;
        xfer_idx = 0;
        violations = 0;
        bus_if.bst_valid = 1'b0;
        bus_if.bst_data  = '0;
        bus_if.bst_last  = 1'b0;
        rst_n = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_psel",     {31'd0, bus_if.psel},      32'd0);
        check("rst_penable",  {31'd0, bus_if.penable},   32'd0);
        check("rst_pwrite",   {31'd0, bus_if.pwrite},    32'd0);
        check("rst_rd_valid", {31'd0, bus_if.rd_valid},  32'd0);
        check("rst_rd_last",  {31'd0, bus_if.rd_last},   32'd0);
        check("rst_err",      {31'd0, bus_if.err},       32'd0);
        check("rst_regs",     {7'd0, bus_if.paddr, bus_if.pwdata, bus_if.rd_data}, 32'd0);
        check("rst_ready",    {31'd0, bus_if.bst_ready}, 32'd1);
        check("rst_idle",     {31'd0, bus_if.idle},      32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write timing: beat accepted in N -> SETUP N+1, ACCESS N+2, ready N+3
        apb_log.delete();
        violations = 0;
        send(8'h80, 1'b0);
        send(8'h20, 1'b0);
        send(8'h99, 1'b0);
        @(negedge clk);
        check("wt_setup", {29'd0, bus_if.psel, bus_if.penable, bus_if.bst_ready}, 32'b100);
        @(negedge clk);
        check("wt_access", {29'd0, bus_if.psel, bus_if.penable, bus_if.bst_ready}, 32'b110);
        check("wt_access_bus", {14'd0, bus_if.pwrite, bus_if.paddr, bus_if.pwdata}, {14'd0, 1'b1, 9'h020, 8'h99});
        @(negedge clk);
        check("wt_ready_again", {29'd0, bus_if.psel, bus_if.penable, bus_if.bst_ready}, 32'b001);
        @(posedge clk);
        #1;
        send(8'h98, 1'b1);
        wait_idle("wt");
        ref_mem[9'h020] = 8'h99;
        ref_mem[9'h021] = 8'h98;
        check("wt_count", apb_log.size(), 2);

        // Read timing: LEN accepted in N -> SETUP N+1, ACCESS N+2, rd_valid N+3
        rd_log.delete();
        rd_rand = 0;
        rd_hold = 0;
        send(8'h00, 1'b0);
        send(8'h20, 1'b0);
        send(8'h01, 1'b1);
        @(negedge clk);
        check("rt_setup", {30'd0, bus_if.psel, bus_if.penable}, 32'b10);
        @(negedge clk);
        check("rt_access", {30'd0, bus_if.psel, bus_if.penable}, 32'b11);
        @(negedge clk);
        check("rt_valid", {14'd0, bus_if.rd_valid, bus_if.rd_last, bus_if.psel, 5'd0, bus_if.rd_data},
              {14'd0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h99});
        @(posedge clk);
        #1;
        wait_idle("rt");

        // Directed table
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                burst_data[i] = vecs[v].d[8*i +: 8];
                if (!vecs[v].wr) begin
                    slave_mem[vecs[v].addr + 9'(i)] = vecs[v].d[8*i +: 8];
                    ref_mem[vecs[v].addr + 9'(i)]   = vecs[v].d[8*i +: 8];
                end
            end
            run_burst(vecs[v].wr, vecs[v].addr, int'(vecs[v].n), {248'd0, vecs[v].mask},
                      vecs[v].exp_err, $sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_last_addr", v),
                  (apb_log.size() > 0) ? {23'd0, apb_log[apb_log.size() - 1].addr} : 32'hFFFF_FFFF,
                  {23'd0, vecs[v].exp_last});
        end

        // Backpressure: rd_ready held off 5 cycles per beat
        rd_hold = 5;
        slave_mem[9'h1FE] = 8'h11; slave_mem[9'h1FF] = 8'h22; slave_mem[9'h000] = 8'h33;
        ref_mem[9'h1FE]   = 8'h11; ref_mem[9'h1FF]   = 8'h22; ref_mem[9'h000]   = 8'h33;
        run_burst(1'b0, 9'h1FE, 3, '0, 1'b0, "bp");
        rd_hold = 0;

        // Malformed: last on CMD, then last on ADDR
        apb_log.delete();
        send(8'h80, 1'b1);
        @(negedge clk);
        check("cmd_last_err_idle", {30'd0, bus_if.err, bus_if.idle}, 32'b11);
        @(posedge clk);
        #1;
        send(8'h80, 1'b0);
        check("addr_last_err_clear", {31'd0, bus_if.err}, 32'd0);
        send(8'h10, 1'b1);
        @(negedge clk);
        check("addr_last_err_idle", {30'd0, bus_if.err, bus_if.idle}, 32'b11);
        repeat (4) @(negedge clk);
        check("addr_last_no_apb", apb_log.size(), 0);
        @(posedge clk);
        #1;

        // LEN 0 with trailing beats: drain, then 256 reads
        apb_log.delete();
        rd_log.delete();
        violations = 0;
        err_mask = '0;
        xfer_idx = 0;
        send(8'h00, 1'b0);
        send(8'h40, 1'b0);
        send(8'h00, 1'b0);
        send(8'h5A, 1'b0);
        check("drain_no_apb", {31'd0, bus_if.psel}, 32'd0);
        send(8'hA5, 1'b1);
        check("drain_apb_empty", apb_log.size(), 0);
        wait_idle("drain");
        compare_logs(1'b0, 9'h040, 256, "drain");

        // Randomized bursts against the reference memory
        rd_rand = 1;
        for (int k = 0; k < 25; k++) begin
            bit         wr;
            logic [8:0] a;
            int         n;
            logic [255:0] m;
            wr = 1'($urandom_range(0, 1));
            a  = 9'($urandom_range(0, 511));
            n  = $urandom_range(1, 6);
            m  = '0;
            for (int i = 0; i < n; i++) begin
                burst_data[i] = 8'($urandom);
                m[i] = ($urandom_range(0, 7) == 0);
            end
            run_burst(wr, a, n, m, |m, $sformatf("rnd%0d", k));
        end
        rd_rand = 0;
        rd_hold = 0;

        // Reset during ACCESS of a read
        rd_log.delete();
        send(8'h00, 1'b0);
        send(8'h80, 1'b0);
        send(8'h04, 1'b1);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus_if.psel && bus_if.penable) break;
        end
        check("rst_mid_in_access", {31'd0, bus_if.penable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_drop", {29'd0, bus_if.psel, bus_if.penable, bus_if.rd_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", {31'd0, bus_if.idle}, 32'd1);
        repeat (5) @(negedge clk);
        check("rst_mid_no_rd", rd_log.size(), 0);
        check("rst_mid_quiet", {30'd0, bus_if.psel, bus_if.rd_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_to_apb_master.md
# burst_to_apb_master

Bridge that accepts an 8-bit valid/ready burst stream and replays it as APB master transfers on a 9-bit address space. It returns read data as a valid/ready burst and is the mirror of the APB-to-burst bridge. It drives the APB slave side of that bridge and any other 9-bit/8-bit APB register block in the design. APB transfers are fixed two-phase (setup, access) with no wait states; `plsverr` is sampled in the access phase.

## Interface
- `ADDR_W`, 9: APB address width; fixed, not to be overridden.
- `DATA_W`, 8: data width for burst beats and APB; fixed.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `bst_valid` in 1: input burst beat valid.
- `bst_ready` out 1: input burst beat accepted when `bst_valid && bst_ready`.
- `bst_data` in 8: input beat payload.
- `bst_last` in 1: final beat of the input burst.
- `paddr` out 9: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable (access phase).
- `pwrite` out 1: APB direction; 1 = write.
- `pwdata` out 8: APB write data.
- `prdata` in 8: APB read data, sampled in the access phase.
- `plsverr` in 1: APB slave error, sampled in the access phase.
- `rd_valid` out 1: read-return beat valid.
- `rd_ready` in 1: read-return beat accepted.
- `rd_data` out 8: read-return payload.
- `rd_last` out 1: final read-return beat.
- `err` out 1: sticky error flag for the current command.
- `idle` out 1: high when no command is in progress.

## Operation
- Burst format:
  - beat 0 = CMD: `[7]` = write, `[0]` = `addr[8]`, other bits ignored.
  - beat 1 = ADDR: `addr[7:0]`.
  - Write: beats 2..n are data, and `bst_last` marks the final data beat.
  - Read: beat 2 = LEN (count of reads; 0 means 256), and `bst_last` is expected on LEN.
- FSM states: IDLE, ADDR, LEN, WDATA, SETUP, ACCESS, RHOLD, DRAIN.
- IDLE, `bst_ready`=1. CMD beat:
  - clears `err`, latches `pwrite` and `addr[8]`;
  - goes to ADDR;
  - if `bst_last` is set on CMD: sets `err` and stays in IDLE.
- ADDR, `bst_ready`=1. Latches `addr[7:0]`.
  - Write goes to WDATA; read goes to LEN.
  - `bst_last` here sets `err` and returns to IDLE.
- LEN, `bst_ready`=1. Loads a 9-bit remaining counter (0 loads 256), then goes to SETUP.
  - If `bst_last`=0 on LEN: goes to DRAIN instead; the read runs only after the drain completes.
- DRAIN, `bst_ready`=1. Discards beats until `bst_last`, then goes to SETUP.
- WDATA, `bst_ready`=1. Accepted beat is latched to `pwdata` and its `bst_last` is remembered; goes to SETUP.
- SETUP: `psel`=1, `penable`=0; goes to ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - `plsverr`=1 sets `err`.
  - Write: increments the address; returns to WDATA, or to IDLE if the remembered `last` is set.
  - Read: captures `prdata` into `rd_data`, sets `rd_valid`, and sets `rd_last` when the counter is 1. Decrements the counter, increments the address, goes to RHOLD.
- RHOLD: holds `rd_valid`/`rd_data`/`rd_last` stable until `rd_ready`. On handshake: goes to SETUP if the counter is nonzero, else to IDLE.
- Address arithmetic is 9-bit modulo: 0x1FF + 1 = 0x000, with no error.
- A transfer that gets an error still completes; the burst continues to its end.
- `paddr`/`pwrite`/`pwdata` are stable from SETUP through ACCESS. `psel`/`penable` are 0 in every other state.
- `idle` = (state == IDLE).
- `bst_ready`=0 in SETUP, ACCESS and RHOLD.
- Reset values: state IDLE; `psel`, `penable`, `pwrite`, `rd_valid`, `rd_last`, `err` = 0; `paddr`, `pwdata`, `rd_data` = 0; `bst_ready`=1; `idle`=1.
- Reset asserted mid-transfer aborts immediately: APB is dropped and no read beat is returned.

## Timing
- Write data beat accepted in cycle N:
  - SETUP in N+1, ACCESS in N+2;
  - `bst_ready` high again in N+3.
  - Throughput is 1 write per 3 cycles.
- LEN accepted in cycle N: SETUP N+1, ACCESS N+2, `rd_valid` N+3.
- `rd_ready` high with `rd_valid` in cycle M: next SETUP in M+1, next `rd_valid` in M+3.
- `err` updates one cycle after the causing edge and holds until the next CMD beat is accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Write burst: CMD 0x80, ADDR 0x10, data 0xA1,0xB2,0xC3 (last on 0xC3).
  - Expect 3 APB writes to 0x010/0x011/0x012 with those data, each 2 cycles.
  - `idle` returns 1; `err`=0.
- Read burst: CMD 0x01, ADDR 0xFE, LEN 3 (last), slave returns 0x11,0x22,0x33.
  - Expect reads at 0x1FE, 0x1FF, 0x000 (wrap).
  - `rd_data` 0x11,0x22,0x33, with `rd_last` only on 0x33.
- Backpressure: same read with `rd_ready` low for 5 cycles per beat.
  - Expect `rd_data` stable and no APB activity while held.
- Slave error: write burst of 2 with `plsverr`=1 on the first access.
  - Expect `err`=1 and the second write still issued.
  - The next CMD beat clears `err`.
- Malformed bursts:
  - `bst_last` on the ADDR beat: expect `err`=1, no APB cycle, back to IDLE.
  - LEN 0 with 2 trailing beats before last: expect the trailing beats to be drained, then 256 reads.
- Reset asserted during ACCESS of a read: expect `psel`/`penable`/`rd_valid` = 0 immediately and `idle`=1 after release.
